// File: rtl/sr_drv_pkg.sv
// Shared types and helpers for the SR latch drive controller.
//   state_t  : command FSM states
//   cmd_t    : which latch input a command drives (s for set, r for clear)
//   cnt_width: register width needed to count 0 .. n-1
package sr_drv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    CHECK = 2'd3
  } state_t;

  typedef enum logic {
    CMD_CLR = 1'b0,
    CMD_SET = 1'b1
  } cmd_t;

  // Bits needed to hold the values 0 .. n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sr_debounce.sv
// Conditions one raw asynchronous request line.
// A two-flop synchronizer feeds a stability counter; the debounced level only
// follows the synchronized input after it has differed from the level for
// DEB_CYCLES consecutive cycles, so shorter glitches are swallowed.
// Ports:
//   clk     : system clock, rising edge
//   rst     : synchronous reset, active-low
//   i_raw   : raw asynchronous request
//   o_rise  : one-cycle pulse in the cycle after the debounced level rises
module sr_debounce
  import sr_drv_pkg::*;
#(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_rise
);

  localparam int CW = cnt_width(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_d;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_raw;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      if (r_sync2 != r_level) begin
        // The level flips on the edge where the count would reach DEB_CYCLES.
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_rise = r_level & ~r_level_d;

endmodule

// File: rtl/sr_drive_ctrl.sv
// Command front-end for the gated SR latch.
// Debounces raw set/clear requests, turns each accepted request into a
// fixed-width s or r pulse followed by a quiet gap, then checks the latch q
// feedback against the tracked expected state. s and r are never high together.
// Ports:
//   clk     : system clock, rising edge
//   rst     : synchronous reset, active-low (shared with the latch)
//   set_raw : raw asynchronous set request
//   clr_raw : raw asynchronous clear request
//   q_fb    : latch q output, fed back
//   err_clr : single-cycle pulse that clears err
//   s, r    : latch set / reset drive (registered)
//   busy    : FSM is not in IDLE (registered)
//   q_exp   : expected latch state (registered)
//   err     : sticky feedback-mismatch flag (registered)
module sr_drive_ctrl
  import sr_drv_pkg::*;
#(
  parameter int DEB_CYCLES   = 4,
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic set_raw,
  input  logic clr_raw,
  input  logic q_fb,
  input  logic err_clr,
  output logic s,
  output logic r,
  output logic busy,
  output logic q_exp,
  output logic err
);

  localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CW      = cnt_width(CNT_MAX);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);

  logic w_set_rise;
  logic w_clr_rise;

  sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_set (
    .clk    (clk),
    .rst    (rst),
    .i_raw  (set_raw),
    .o_rise (w_set_rise)
  );

  sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
    .clk    (clk),
    .rst    (rst),
    .i_raw  (clr_raw),
    .o_rise (w_clr_rise)
  );

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  cmd_t          r_cmd;
  logic          r_pend_set;
  logic          r_pend_clr;
  logic          r_s;
  logic          r_r;
  logic          r_busy;
  logic          r_q_exp;
  logic          r_err;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  cmd_t          w_cmd_nxt;
  logic          w_s_nxt;
  logic          w_r_nxt;
  logic          w_q_exp_nxt;
  logic          w_err_nxt;
  logic          w_take_set;
  logic          w_take_clr;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cmd_nxt   = r_cmd;
    w_s_nxt     = 1'b0;
    w_r_nxt     = 1'b0;
    w_q_exp_nxt = r_q_exp;
    w_err_nxt   = r_err & ~err_clr;
    w_take_set  = 1'b0;
    w_take_clr  = 1'b0;

    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        // Clear has priority; a request that would not change the latch is
        // consumed without a pulse. A losing set stays pending.
        if (r_pend_clr) begin
          w_take_clr = 1'b1;
          if (r_q_exp) begin
            w_state_nxt = PULSE;
            w_cmd_nxt   = CMD_CLR;
            w_r_nxt     = 1'b1;
          end
        end else if (r_pend_set) begin
          w_take_set = 1'b1;
          if (!r_q_exp) begin
            w_state_nxt = PULSE;
            w_cmd_nxt   = CMD_SET;
            w_s_nxt     = 1'b1;
          end
        end
      end
      PULSE: begin
        if (r_cnt == PULSE_LAST) begin
          w_state_nxt = GAP;
          w_cnt_nxt   = '0;
          w_q_exp_nxt = (r_cmd == CMD_SET);
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
          w_s_nxt   = (r_cmd == CMD_SET);
          w_r_nxt   = (r_cmd == CMD_CLR);
        end
      end
      GAP: begin
        if (r_cnt == GAP_LAST) begin
          w_state_nxt = CHECK;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      CHECK: begin
        w_state_nxt = IDLE;
        // A mismatch overrides a coincident err_clr.
        if (q_fb != r_q_exp) begin
          w_err_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // ---- state and registered outputs ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_cmd      <= CMD_CLR;
      r_pend_set <= 1'b0;
      r_pend_clr <= 1'b0;
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_busy     <= 1'b0;
      r_q_exp    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_cmd      <= w_cmd_nxt;
      // A fresh rise on the consuming edge re-arms the flag.
      r_pend_set <= (r_pend_set & ~w_take_set) | w_set_rise;
      r_pend_clr <= (r_pend_clr & ~w_take_clr) | w_clr_rise;
      r_s        <= w_s_nxt;
      r_r        <= w_r_nxt;
      r_busy     <= (w_state_nxt != IDLE);
      r_q_exp    <= w_q_exp_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign s     = r_s;
  assign r     = r_r;
  assign busy  = r_busy;
  assign q_exp = r_q_exp;
  assign err   = r_err;

endmodule
